// File: rtl/calculate_new_capacity_block.sv
// Parking slot map updater: toggles the one-hot selected slot of the supplied map and reports occupancy.
// Latency: one clk edge from a sampled in_valid to registered outputs; out_valid pulses for that cycle.
// Backpressure: none; every in_valid request is accepted, and malformed selects pass the map unchanged with an error flag.
module calculate_new_capacity_block #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           park_location,
  input  logic [WIDTH-1:0]           parking_capacity,
  output logic [WIDTH-1:0]           new_capacity,
  output logic                       out_valid,
  output logic                       err_not_onehot,
  output logic [$clog2(WIDTH+1)-1:0] occupied_count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             onehot;
  logic [WIDTH-1:0] new_capacity_d, new_capacity_q;
  logic             err_d, err_q;
  logic [CW-1:0]    count_d, count_q;
  logic             full_d, full_q;
  logic             empty_d, empty_q;
  logic             out_valid_q;

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves nothing.
  always_comb begin
    onehot = (park_location != '0) &&
             ((park_location & (park_location - ONE)) == '0);
  end

  // Next map: toggle the selected slot, or pass the map through when the select is malformed.
  always_comb begin
    new_capacity_d = parking_capacity;
    err_d          = 1'b1;
    if (onehot) begin
      new_capacity_d = parking_capacity ^ park_location;
      err_d          = 1'b0;
    end
  end

  // Occupancy figures derived from the value being loaded so they always match the map.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_d = count_d + CW'(new_capacity_d[i]);
    end
    full_d  = (count_d == CW'(WIDTH));
    empty_d = (count_d == '0);
  end

  // Output registers: load on an accepted request, hold otherwise; async reset clears to the empty map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_capacity_q <= '0;
      err_q          <= 1'b0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      out_valid_q    <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        new_capacity_q <= new_capacity_d;
        err_q          <= err_d;
        count_q        <= count_d;
        full_q         <= full_d;
        empty_q        <= empty_d;
      end
    end
  end

  assign new_capacity   = new_capacity_q;
  assign out_valid      = out_valid_q;
  assign err_not_onehot = err_q;
  assign occupied_count = count_q;
  assign full           = full_q;
  assign empty          = empty_q;

endmodule

// File: tb/tb_calculate_new_capacity_block.sv
// Bench for calculate_new_capacity_block: directed vectors with literal expectations plus random traffic.
// Outputs are compared every falling edge against a behavioural model updated on rising edges.
// Reset is exercised at start and asynchronously mid-cycle.
module tb_calculate_new_capacity_block;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  park_location = '0;
  logic [W-1:0]  parking_capacity = '0;
  logic [W-1:0]  new_capacity;
  logic          out_valid;
  logic          err_not_onehot;
  logic [CW-1:0] occupied_count;
  logic          full;
  logic          empty;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model state
  logic [W-1:0] m_nc = '0;
  logic         m_ov = 1'b0;
  logic         m_err = 1'b0;
  int           m_cnt = 0;

  calculate_new_capacity_block #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .park_location(park_location), .parking_capacity(parking_capacity),
    .new_capacity(new_capacity), .out_valid(out_valid),
    .err_not_onehot(err_not_onehot), .occupied_count(occupied_count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: toggle the selected slot if exactly one slot is named, else keep the map.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_nc <= '0; m_ov <= 1'b0; m_err <= 1'b0; m_cnt <= 0;
    end else begin
      m_ov <= in_valid;
      if (in_valid) begin
        if ($countones(park_location) == 1) begin
          m_nc  <= parking_capacity ^ park_location;
          m_err <= 1'b0;
          m_cnt <= $countones(parking_capacity ^ park_location);
        end else begin
          m_nc  <= parking_capacity;
          m_err <= 1'b1;
          m_cnt <= $countones(parking_capacity);
        end
      end
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_new_capacity", 32'(new_capacity), 32'(m_nc));
      chk("m_out_valid", 32'(out_valid), 32'(m_ov));
      chk("m_err", 32'(err_not_onehot), 32'(m_err));
      chk("m_count", 32'(occupied_count), 32'(m_cnt));
      chk("m_full", 32'(full), 32'(m_cnt == W));
      chk("m_empty", 32'(empty), 32'(m_cnt == 0));
    end
  end

  task automatic req(input logic [W-1:0] loc, input logic [W-1:0] cap,
                     input logic [W-1:0] e_nc, input logic e_err, input int e_cnt,
                     input logic e_full, input logic e_empty, input string name);
    @(negedge clk);
    in_valid = 1'b1; park_location = loc; parking_capacity = cap;
    @(posedge clk);
    #1;
    chk({name, "_nc"}, 32'(new_capacity), 32'(e_nc));
    chk({name, "_ov"}, 32'(out_valid), 32'd1);
    chk({name, "_err"}, 32'(err_not_onehot), 32'(e_err));
    chk({name, "_cnt"}, 32'(occupied_count), 32'(e_cnt));
    chk({name, "_full"}, 32'(full), 32'(e_full));
    chk({name, "_empty"}, 32'(empty), 32'(e_empty));
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_nc"}, 32'(new_capacity), 32'd0);
    chk({name, "_ov"}, 32'(out_valid), 32'd0);
    chk({name, "_err"}, 32'(err_not_onehot), 32'd0);
    chk({name, "_cnt"}, 32'(occupied_count), 32'd0);
    chk({name, "_full"}, 32'(full), 32'd0);
    chk({name, "_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    logic [W-1:0] held;
    #12;
    chk_reset_vals("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // arrivals
    req(8'b10000000, 8'b01101100, 8'b11101100, 0, 5, 0, 0, "arr0");
    req(8'b00010000, 8'b11101111, 8'b11111111, 0, 8, 1, 0, "arr1");
    req(8'b00000100, 8'b10100000, 8'b10100100, 0, 3, 0, 0, "arr2");
    req(8'b00000001, 8'b10001000, 8'b10001001, 0, 3, 0, 0, "arr3");
    // departures
    req(8'b10000000, 8'b11101100, 8'b01101100, 0, 4, 0, 0, "dep0");
    req(8'b00010000, 8'b11111111, 8'b11101111, 0, 7, 0, 0, "dep1");
    req(8'b00000100, 8'b10100100, 8'b10100000, 0, 2, 0, 0, "dep2");
    req(8'b00000001, 8'b10001001, 8'b10001000, 0, 2, 0, 0, "dep3");
    // malformed selects, then recovery
    req(8'b00000000, 8'b10101010, 8'b10101010, 1, 4, 0, 0, "err0");
    req(8'b00000011, 8'b01010101, 8'b01010101, 1, 4, 0, 0, "err1");
    req(8'b00000001, 8'b00000000, 8'b00000001, 0, 1, 0, 0, "clr");
    // empty boundary
    req(8'b00000001, 8'b00000001, 8'b00000000, 0, 0, 0, 1, "empty");

    // hold: inputs change but in_valid stays low
    held = new_capacity;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      park_location = 8'b00000010; parking_capacity = 8'($urandom);
    end
    chk("hold_nc", 32'(new_capacity), 32'(held));
    chk("hold_ov", 32'(out_valid), 32'd0);
    chk("hold_empty", 32'(empty), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0:       park_location = '0;
        1:       park_location = 8'($urandom);
        default: park_location = 8'(1 << $urandom_range(0, W - 1));
      endcase
      case ($urandom_range(0, 5))
        0:       parking_capacity = 8'hFF ^ park_location;
        1:       parking_capacity = park_location;
        default: parking_capacity = 8'($urandom);
      endcase
    end

    // async reset between edges with a request pending
    @(negedge clk);
    in_valid = 1'b1; park_location = 8'b00001000; parking_capacity = 8'b11110111;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_nc", 32'(new_capacity), 32'hFF);
    chk("post_rst_full", 32'(full), 32'd1);
    chk("post_rst_ov", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
